ex_mem_branch_stage: RTL and testbench
======================================

Name: ex_mem_branch_stage

Overview:
- Pipeline stage directly downstream of the EX-stage ALU in the 5-stage RISC-V core.
- Consumes the ALU result and its zero/neg flags and resolves conditional branches and jumps.
- Registers the EX/MEM pipeline fields, with stall (hold) and flush (bubble) control.
- Runs a two-state redirect FSM that drives the PC mux and squashes wrong-path instructions in IF/ID, ID/EX and EX.

Parameters:
- N, 32, datapath width (ALU result, PC, store data).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold EX/MEM contents (memory-side stall).
- flush  in  1  external squash: capture a bubble into EX/MEM.
- ex_valid  in  1  EX instruction is valid.
- alu_w  in  N  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_neg  in  1  ALU sign flag (unused for branch decisions; forwarded to mem_neg).
- ex_rs2  in  N  store data.
- ex_rd  in  5  destination register.
- ex_pc_target  in  N  PC+imm branch/JAL target.
- ex_pc_plus4  in  N  link value.
- ex_branch  in  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 JAL, 110 JALR, 111 reserved (treated as none).
- ex_reg_write  in  1  control field.
- ex_mem_write  in  1  control field.
- ex_result_src  in  2  control field.
- mem_valid  out  1  EX/MEM holds a valid instruction.
- mem_alu_w  out  N  registered ALU result.
- mem_neg  out  1  registered alu_neg.
- mem_wdata  out  N  registered store data.
- mem_rd  out  5  registered destination register.
- mem_reg_write  out  1  qualified by mem_valid.
- mem_mem_write  out  1  qualified by mem_valid.
- mem_result_src  out  2  registered control field.
- mem_pc_plus4  out  N  registered link value.
- pc_src  out  1  select pc_redirect as next PC.
- pc_redirect  out  N  redirect target.
- flush_if_id  out  1  squash IF/ID.
- flush_id_ex  out  1  squash ID/EX.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All mem_* outputs, pc_redirect and any enabled counters are 0.
  - FSM state is RUN; pc_src, flush_if_id and flush_id_ex are 0.
- Condition rules. The EX stage drives the ALU opcode for branches as follows:
  - BEQ/BNE use SUB. BEQ taken iff alu_zero; BNE taken iff !alu_zero.
  - BLT/BGE use SLT, so comparisons are signed and overflow-exact. BLT taken iff !alu_zero (alu_w==1); BGE taken iff alu_zero.
  - JAL and JALR are always taken.
  - alu_neg is not used for branch decisions.
- Targets: JALR target = alu_w with bit 0 forced to 0; all other taken branches use ex_pc_target.
- Capture (each clk, priority top-down):
  - rst.
  - redirect_state==REDIRECT or flush → capture a bubble: mem_valid=0, mem_reg_write=0, mem_mem_write=0; data fields are don't-care but held.
  - stall → hold all mem_* outputs.
  - Otherwise → load all ex_* fields; mem_valid=ex_valid; write enables ANDed with ex_valid.
- Taken qualifier: taken = ex_valid & condition & state==RUN & !stall & !flush. A stalled branch resolves in the cycle its stall drops.
- FSM:
  - RUN: if taken, register the target into pc_redirect and go to REDIRECT.
  - REDIRECT (exactly 1 cycle, combinational from state): pc_src=1, flush_if_id=1, flush_id_ex=1, and the current EX instruction is captured as a bubble.
    - Leaves for RUN unconditionally, even if stall=1; redirect takes precedence over stall.
    - Any branch presented in EX during REDIRECT is wrong-path and is ignored.
- Latency:
  - EX/MEM fields appear 1 cycle after capture.
  - Redirect is asserted in the cycle after the branch is in EX; the branch itself commits normally into EX/MEM.
  - Wrong-path penalty: 3 instructions (IF, ID, EX).
- Reset mid-REDIRECT: returns to RUN next edge with no redirect.
- Back-to-back branches: the second branch is necessarily squashed, so only one redirect occurs.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: adds 32-bit outputs br_resolved_cnt and br_taken_cnt.
  - br_resolved_cnt increments on each qualified branch/jump evaluation (ex_valid & ex_branch in 001..110 & RUN & !stall & !flush).
  - br_taken_cnt increments on each transition to REDIRECT.
  - Both clear on rst and wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles with random inputs → all outputs 0, mem_valid=0, pc_src=0.
- ALU op: ex_valid=1, ex_branch=000, alu_w=0x0000_0010, ex_rd=5, ex_reg_write=1 → next cycle mem_alu_w=0x10, mem_rd=5, mem_reg_write=1, pc_src=0.
- Conditional branches: BEQ with alu_zero=1, ex_pc_target=0x0000_0100 → next cycle pc_src=1, pc_redirect=0x100, both flushes=1, and the following cycle mem_valid=0. BNE with alu_zero=1 → no redirect.
- BLT/BGE via SLT:
  - BLT with alu_w=1, alu_zero=0 → redirect.
  - BGE with same inputs → no redirect.
  - JALR with alu_w=0x0000_0203 → pc_redirect=0x0000_0202.
- Stall and flush:
  - BEQ taken held under stall=1 for 3 cycles → no redirect and EX/MEM held; stall drops → redirect next cycle.
  - Branch in EX with flush=1 → bubble captured and no redirect.
- Back-to-back and reset mid-redirect:
  - Two taken BEQs in consecutive cycles → exactly one pc_src pulse, targeting the first branch's target.
  - rst asserted in the REDIRECT cycle → pc_src=0 after the edge.

Source files
------------

// File: rtl/ex_mem_branch_if.sv
// EX -> EX/MEM bundle: EX-side fields and stall/flush in, registered MEM fields and redirect controls out.
// Optional BRANCH_STATS_EN adds the branch statistics counters to the bundle.
interface ex_mem_branch_if #(parameter int N = 32);
    logic           stall;
    logic           flush;
    logic           ex_valid;
    logic [N-1:0]   alu_w;
    logic           alu_zero;
    logic           alu_neg;
    logic [N-1:0]   ex_rs2;
    logic [4:0]     ex_rd;
    logic [N-1:0]   ex_pc_target;
    logic [N-1:0]   ex_pc_plus4;
    logic [2:0]     ex_branch;
    logic           ex_reg_write;
    logic           ex_mem_write;
    logic [1:0]     ex_result_src;

    logic           mem_valid;
    logic [N-1:0]   mem_alu_w;
    logic           mem_neg;
    logic [N-1:0]   mem_wdata;
    logic [4:0]     mem_rd;
    logic           mem_reg_write;
    logic           mem_mem_write;
    logic [1:0]     mem_result_src;
    logic [N-1:0]   mem_pc_plus4;
    logic           pc_src;
    logic [N-1:0]   pc_redirect;
    logic           flush_if_id;
    logic           flush_id_ex;

`ifdef BRANCH_STATS_EN
    logic [31:0]    br_resolved_cnt;
    logic [31:0]    br_taken_cnt;

    modport master (
        output stall, flush, ex_valid, alu_w, alu_zero, alu_neg, ex_rs2, ex_rd,
               ex_pc_target, ex_pc_plus4, ex_branch, ex_reg_write, ex_mem_write, ex_result_src,
        input  mem_valid, mem_alu_w, mem_neg, mem_wdata, mem_rd, mem_reg_write, mem_mem_write,
               mem_result_src, mem_pc_plus4, pc_src, pc_redirect, flush_if_id, flush_id_ex,
               br_resolved_cnt, br_taken_cnt
    );
    modport slave (
        input  stall, flush, ex_valid, alu_w, alu_zero, alu_neg, ex_rs2, ex_rd,
               ex_pc_target, ex_pc_plus4, ex_branch, ex_reg_write, ex_mem_write, ex_result_src,
        output mem_valid, mem_alu_w, mem_neg, mem_wdata, mem_rd, mem_reg_write, mem_mem_write,
               mem_result_src, mem_pc_plus4, pc_src, pc_redirect, flush_if_id, flush_id_ex,
               br_resolved_cnt, br_taken_cnt
    );
`else
    modport master (
        output stall, flush, ex_valid, alu_w, alu_zero, alu_neg, ex_rs2, ex_rd,
               ex_pc_target, ex_pc_plus4, ex_branch, ex_reg_write, ex_mem_write, ex_result_src,
        input  mem_valid, mem_alu_w, mem_neg, mem_wdata, mem_rd, mem_reg_write, mem_mem_write,
               mem_result_src, mem_pc_plus4, pc_src, pc_redirect, flush_if_id, flush_id_ex
    );
    modport slave (
        input  stall, flush, ex_valid, alu_w, alu_zero, alu_neg, ex_rs2, ex_rd,
               ex_pc_target, ex_pc_plus4, ex_branch, ex_reg_write, ex_mem_write, ex_result_src,
        output mem_valid, mem_alu_w, mem_neg, mem_wdata, mem_rd, mem_reg_write, mem_mem_write,
               mem_result_src, mem_pc_plus4, pc_src, pc_redirect, flush_if_id, flush_id_ex
    );
`endif
endinterface

// File: rtl/ex_mem_branch_stage.sv
// EX/MEM register with branch resolution and a RUN/REDIRECT FSM; redirect is 1 cycle after the branch is in EX.
// Stall holds EX/MEM, flush/redirect capture a bubble (redirect beats stall). Optional counters: BRANCH_STATS_EN.
module ex_mem_branch_stage #(
    parameter int N = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    ex_mem_branch_if.slave         io_stage
);
    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b011;
    localparam logic [2:0] BR_BGE  = 3'b100;
    localparam logic [2:0] BR_JAL  = 3'b101;
    localparam logic [2:0] BR_JALR = 3'b110;
    localparam logic [2:0] BR_RSVD = 3'b111;

    typedef enum logic {S_RUN = 1'b0, S_REDIRECT = 1'b1} state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           w_cond;
    logic           w_is_branch;
    logic           w_resolve;
    logic           w_taken;
    logic [N-1:0]   w_target;
    logic           w_pc_src;
    logic           w_flush_if_id;
    logic           w_flush_id_ex;

    logic           r_mem_valid;
    logic [N-1:0]   r_mem_alu_w;
    logic           r_mem_neg;
    logic [N-1:0]   r_mem_wdata;
    logic [4:0]     r_mem_rd;
    logic           r_mem_reg_write;
    logic           r_mem_mem_write;
    logic [1:0]     r_mem_result_src;
    logic [N-1:0]   r_mem_pc_plus4;
    logic [N-1:0]   r_pc_redirect;

    // BLT/BGE arrive as SLT results, so the zero flag alone decides them.
    always_comb begin
        w_cond = 1'b0;
        case (io_stage.ex_branch)
            BR_BEQ:  w_cond = io_stage.alu_zero;
            BR_BNE:  w_cond = ~io_stage.alu_zero;
            BR_BLT:  w_cond = ~io_stage.alu_zero;
            BR_BGE:  w_cond = io_stage.alu_zero;
            BR_JAL:  w_cond = 1'b1;
            BR_JALR: w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_is_branch = (io_stage.ex_branch != BR_NONE) && (io_stage.ex_branch != BR_RSVD);
    assign w_resolve   = io_stage.ex_valid & w_is_branch & (r_state == S_RUN)
                       & ~io_stage.stall & ~io_stage.flush;
    assign w_taken     = w_resolve & w_cond;
    assign w_target    = (io_stage.ex_branch == BR_JALR) ? {io_stage.alu_w[N-1:1], 1'b0}
                                                         : io_stage.ex_pc_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:      if (w_taken) w_state_nxt = S_REDIRECT;
            S_REDIRECT: w_state_nxt = S_RUN;
            default:    w_state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        w_pc_src      = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        if (r_state == S_REDIRECT) begin
            w_pc_src      = 1'b1;
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_redirect <= '0;
        end else if (w_taken) begin
            r_pc_redirect <= w_target;
        end
    end

    // The instruction sitting in EX during REDIRECT is wrong-path: bubble it even when stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_valid      <= 1'b0;
            r_mem_alu_w      <= '0;
            r_mem_neg        <= 1'b0;
            r_mem_wdata      <= '0;
            r_mem_rd         <= '0;
            r_mem_reg_write  <= 1'b0;
            r_mem_mem_write  <= 1'b0;
            r_mem_result_src <= '0;
            r_mem_pc_plus4   <= '0;
        end else if ((r_state == S_REDIRECT) || io_stage.flush) begin
            r_mem_valid      <= 1'b0;
            r_mem_reg_write  <= 1'b0;
            r_mem_mem_write  <= 1'b0;
        end else if (!io_stage.stall) begin
            r_mem_valid      <= io_stage.ex_valid;
            r_mem_alu_w      <= io_stage.alu_w;
            r_mem_neg        <= io_stage.alu_neg;
            r_mem_wdata      <= io_stage.ex_rs2;
            r_mem_rd         <= io_stage.ex_rd;
            r_mem_reg_write  <= io_stage.ex_reg_write & io_stage.ex_valid;
            r_mem_mem_write  <= io_stage.ex_mem_write & io_stage.ex_valid;
            r_mem_result_src <= io_stage.ex_result_src;
            r_mem_pc_plus4   <= io_stage.ex_pc_plus4;
        end
    end

    assign io_stage.mem_valid      = r_mem_valid;
    assign io_stage.mem_alu_w      = r_mem_alu_w;
    assign io_stage.mem_neg        = r_mem_neg;
    assign io_stage.mem_wdata      = r_mem_wdata;
    assign io_stage.mem_rd         = r_mem_rd;
    assign io_stage.mem_reg_write  = r_mem_reg_write;
    assign io_stage.mem_mem_write  = r_mem_mem_write;
    assign io_stage.mem_result_src = r_mem_result_src;
    assign io_stage.mem_pc_plus4   = r_mem_pc_plus4;
    assign io_stage.pc_src         = w_pc_src;
    assign io_stage.pc_redirect    = r_pc_redirect;
    assign io_stage.flush_if_id    = w_flush_if_id;
    assign io_stage.flush_id_ex    = w_flush_id_ex;

`ifdef BRANCH_STATS_EN
    logic [31:0]    r_br_resolved_cnt;
    logic [31:0]    r_br_taken_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_resolved_cnt <= '0;
            r_br_taken_cnt    <= '0;
        end else begin
            if (w_resolve) r_br_resolved_cnt <= r_br_resolved_cnt + 32'd1;
            if (w_taken)   r_br_taken_cnt    <= r_br_taken_cnt + 32'd1;
        end
    end

    assign io_stage.br_resolved_cnt = r_br_resolved_cnt;
    assign io_stage.br_taken_cnt    = r_br_taken_cnt;
`endif

endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// Randomized scoreboard bench for ex_mem_branch_stage: stimulus pushes predicted outputs, a monitor pops and compares.
module tb_ex_mem_branch_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_mem_branch_if #(.N(32)) bus ();
    ex_mem_branch_stage #(.N(32)) dut (.clk(clk), .rst(rst), .io_stage(bus));

    typedef struct {
        logic        rst, stall, flush, ex_valid, zero, neg, rw, mw;
        logic [31:0] alu_w, rs2, tgt, pc4;
        logic [4:0]  rd;
        logic [2:0]  br;
        logic [1:0]  rs;
    } stim_t;

    typedef struct {
        logic        valid, neg, rw, mw, pc_src;
        logic [31:0] alu_w, wdata, pc4, redir, res_cnt, tak_cnt;
        logic [4:0]  rd;
        logic [1:0]  rs;
    } exp_t;

    exp_t q[$];
    exp_t m;
    logic m_redirecting;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.rst      = ($urandom_range(0, 49) == 0);
        s.stall    = ($urandom_range(0, 4) == 0);
        s.flush    = ($urandom_range(0, 7) == 0);
        s.ex_valid = ($urandom_range(0, 5) != 0);
        s.zero     = $urandom_range(0, 1);
        s.neg      = $urandom_range(0, 1);
        s.rw       = $urandom_range(0, 1);
        s.mw       = $urandom_range(0, 1);
        s.alu_w    = $urandom;
        s.rs2      = $urandom;
        s.tgt      = $urandom;
        s.pc4      = $urandom;
        s.rd       = 5'($urandom);
        s.br       = 3'($urandom);
        s.rs       = 2'($urandom);
        return s;
    endfunction

    // Branch rule table: which branch kinds redirect for a given zero flag.
    function automatic bit br_taken(input logic [2:0] br, input logic zero);
        case (br)
            3'd1: return zero;
            3'd2: return !zero;
            3'd3: return !zero;
            3'd4: return zero;
            3'd5, 3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(input stim_t s);
        bit evaluated, taken;
        @(negedge clk);
        rst                 = s.rst;
        bus.stall           = s.stall;
        bus.flush           = s.flush;
        bus.ex_valid        = s.ex_valid;
        bus.alu_w           = s.alu_w;
        bus.alu_zero        = s.zero;
        bus.alu_neg         = s.neg;
        bus.ex_rs2          = s.rs2;
        bus.ex_rd           = s.rd;
        bus.ex_pc_target    = s.tgt;
        bus.ex_pc_plus4     = s.pc4;
        bus.ex_branch       = s.br;
        bus.ex_reg_write    = s.rw;
        bus.ex_mem_write    = s.mw;
        bus.ex_result_src   = s.rs;
        if (s.rst) begin
            m = '{default: '0};
            m_redirecting = 1'b0;
        end else begin
            evaluated = s.ex_valid && s.br inside {[3'd1:3'd6]} && !m_redirecting && !s.stall && !s.flush;
            taken     = evaluated && br_taken(s.br, s.zero);
            if (m_redirecting || s.flush) begin
                m.valid = 0; m.rw = 0; m.mw = 0;
            end else if (!s.stall) begin
                m.valid = s.ex_valid; m.alu_w = s.alu_w; m.neg = s.neg; m.wdata = s.rs2;
                m.rd = s.rd; m.rw = s.rw && s.ex_valid; m.mw = s.mw && s.ex_valid;
                m.rs = s.rs; m.pc4 = s.pc4;
            end
            if (taken) m.redir = (s.br == 3'd6) ? (s.alu_w & 32'hFFFF_FFFE) : s.tgt;
            if (evaluated) m.res_cnt = m.res_cnt + 1;
            if (taken) m.tak_cnt = m.tak_cnt + 1;
            m_redirecting = taken;
            m.pc_src = taken;
        end
        q.push_back(m);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("mem_valid",      32'(bus.mem_valid),      32'(e.valid));
                chk("mem_alu_w",      bus.mem_alu_w,           e.alu_w);
                chk("mem_neg",        32'(bus.mem_neg),        32'(e.neg));
                chk("mem_wdata",      bus.mem_wdata,           e.wdata);
                chk("mem_rd",         32'(bus.mem_rd),         32'(e.rd));
                chk("mem_reg_write",  32'(bus.mem_reg_write),  32'(e.rw));
                chk("mem_mem_write",  32'(bus.mem_mem_write),  32'(e.mw));
                chk("mem_result_src", 32'(bus.mem_result_src), 32'(e.rs));
                chk("mem_pc_plus4",   bus.mem_pc_plus4,        e.pc4);
                chk("pc_src",         32'(bus.pc_src),         32'(e.pc_src));
                chk("flush_if_id",    32'(bus.flush_if_id),    32'(e.pc_src));
                chk("flush_id_ex",    32'(bus.flush_id_ex),    32'(e.pc_src));
                chk("pc_redirect",    bus.pc_redirect,         e.redir);
`ifdef BRANCH_STATS_EN
                chk("br_resolved_cnt", bus.br_resolved_cnt,    e.res_cnt);
                chk("br_taken_cnt",    bus.br_taken_cnt,       e.tak_cnt);
`endif
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        int    guard;
        m = '{default: '0};
        m_redirecting = 1'b0;

        // reset with random data on the inputs
        for (int i = 0; i < 2; i++) begin s = rnd(); s.rst = 1; step(s); end

        // plain ALU op
        s = idle(); s.ex_valid = 1; s.alu_w = 32'h10; s.rd = 5; s.rw = 1; step(s);
        step(idle());

        // BEQ taken, then BNE not taken
        s = idle(); s.ex_valid = 1; s.br = 3'd1; s.zero = 1; s.tgt = 32'h100; step(s);
        step(idle()); step(idle());
        s.br = 3'd2; step(s); step(idle());

        // BLT / BGE on an SLT result of 1, then JALR
        s = idle(); s.ex_valid = 1; s.br = 3'd3; s.alu_w = 1; s.zero = 0; s.tgt = 32'h440; step(s);
        step(idle());
        s.br = 3'd4; step(s); step(idle());
        s = idle(); s.ex_valid = 1; s.br = 3'd6; s.alu_w = 32'h203; step(s);
        step(idle()); step(idle());

        // stalled taken BEQ resolves when stall drops
        s = idle(); s.ex_valid = 1; s.br = 3'd1; s.zero = 1; s.tgt = 32'h800; s.rd = 7; s.rw = 1;
        s.stall = 1;
        for (int i = 0; i < 3; i++) step(s);
        s.stall = 0; step(s); step(idle()); step(idle());

        // branch under flush
        s.flush = 1; s.tgt = 32'h900; step(s); step(idle());

        // back-to-back taken BEQs
        s = idle(); s.ex_valid = 1; s.br = 3'd1; s.zero = 1; s.tgt = 32'hA00; step(s);
        s.tgt = 32'hB00; step(s); step(idle()); step(idle());

        // reset while redirecting
        s = idle(); s.ex_valid = 1; s.br = 3'd5; s.tgt = 32'hC00; step(s);
        s = idle(); s.rst = 1; step(s); step(idle());

        for (int i = 0; i < 3000; i++) step(rnd());
        step(idle());

        guard = 0;
        while (q.size() > 0 && guard < 20) begin @(posedge clk); guard++; end
        #2;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
